// File: rtl/fft_zero_pad.sv
// fft_zero_pad: streams a SIZE x SIZE tile in row-major order and re-emits it zero-padded to
// OUT_SIZE x OUT_SIZE (OUT_SIZE = 2*SIZE-1) ahead of the 2-D FFT. It has a single registered
// output stage and valid/ready handshakes on both sides.
module fft_zero_pad #(
  parameter int unsigned  SIZE     = 7,
  parameter int unsigned  DATA_W   = 32,
  localparam int unsigned OUT_SIZE = 2 * SIZE - 1,
  localparam int unsigned IDX_W    = $clog2(OUT_SIZE)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [IDX_W-1:0]  o_out_row,
  output logic [IDX_W-1:0]  o_out_col,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(OUT_SIZE - 1);
  localparam logic [IDX_W-1:0] TileEdge = IDX_W'(SIZE);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              r_state;
  logic [IDX_W-1:0]    r_row;
  logic [IDX_W-1:0]    r_col;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [IDX_W-1:0]    r_out_row;
  logic [IDX_W-1:0]    r_out_col;
  logic                r_out_last;
  logic                r_frame_done;

  logic                w_inside;
  logic                w_slot;
  logic                w_step;
  logic                w_load;
  logic                w_last_pos;

  // Position decode and load qualification for the current cycle.
  always_comb begin
    w_inside   = (r_row < TileEdge) && (r_col < TileEdge);
    // Output register can take a new element when empty or draining this cycle.
    w_slot     = !r_out_valid || i_out_ready;
    w_step     = (r_state == StRun) && i_en && w_slot;
    // Padding positions load a zero without waiting for the upstream side.
    w_load     = w_step && (!w_inside || i_in_valid);
    w_last_pos = (r_row == LastIdx) && (r_col == LastIdx);
  end

  // Frame FSM, position counters and the registered output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_row        <= '0;
      r_col        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_out_valid && i_out_ready && r_out_last;

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_inside ? i_in_data : '0;
        r_out_row   <= r_row;
        r_out_col   <= r_col;
        r_out_last  <= w_last_pos;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          r_row <= '0;
          r_col <= '0;
          if (i_en) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_load) begin
            if (w_last_pos) begin
              r_state <= StIdle;
              r_row   <= '0;
              r_col   <= '0;
            end else if (r_col == LastIdx) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_in_ready   = w_step && w_inside;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_row    = r_out_row;
  assign o_out_col    = r_out_col;
  assign o_out_last   = r_out_last;
  assign o_busy       = (r_state == StRun) || r_out_valid;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_fft_zero_pad.sv
// Directed bench for fft_zero_pad (SIZE=7): every output element is checked against a
// row-major model of the padded frame; scenarios cover stalls, gaps, pauses and reset.
module tb_fft_zero_pad;

  localparam int SIZE = 7;
  localparam int OUT  = 13;
  localparam int NIN  = 49;
  localparam int NOUT = 169;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic        out_last;
  logic        busy;
  logic        frame_done;

  int          vectors = 0;
  int          errors = 0;
  int          in_total = 0;
  int          out_total = 0;
  int          fd_count = 0;
  int          gaps = 0;
  logic        prev_last_hs = 1'b0;
  logic        held_valid = 1'b0;
  logic [31:0] held_data = '0;
  logic [3:0]  held_row = '0;
  logic [3:0]  held_col = '0;
  logic        s_out_valid = 1'b0;
  logic        s_in_ready = 1'b0;

  always #5 clk = ~clk;

  fft_zero_pad #(
    .SIZE  (SIZE),
    .DATA_W(32)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_row   (out_row),
    .o_out_col   (out_col),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_frame_done(frame_done)
  );

  // Input n of the stream: frame f = n/49 carries 100*f + r + c.
  function automatic int exp_in(input int n);
    int k;
    k = n % NIN;
    return 100 * (n / NIN) + k / SIZE + k % SIZE;
  endfunction

  // Elements loaded into the DUT so far (handshaken plus the one held); valid at negedge.
  function automatic int loaded();
    return out_total + int'(out_valid);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    in_total = 0;
    out_total = 0;
    fd_count = 0;
    gaps = 0;
    prev_last_hs = 1'b0;
    held_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // One clock cycle entered and left at a negedge: drive, check the output stream, advance.
  task automatic stream_cycle(input logic e, input logic v, input logic rdy);
    int k, er, ec;
    logic [31:0] ed;
    logic hs_in;
    en = e;
    in_valid = v;
    out_ready = rdy;
    in_data = 32'(exp_in(in_total));
    #1;
    s_out_valid = out_valid;
    s_in_ready = in_ready;
    if (held_valid) begin
      vectors++;
      if (out_data !== held_data || out_row !== held_row || out_col !== held_col) begin
        errors++;
        $display("FAIL hold_stable: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", out_data, out_row,
                 out_col, held_data, held_row, held_col);
      end
    end
    vectors++;
    if (frame_done !== prev_last_hs) begin
      errors++;
      $display("FAIL frame_done: got %b want %b", frame_done, prev_last_hs);
    end
    hs_in = in_valid && in_ready;
    prev_last_hs = out_valid && out_ready && out_last;
    if (out_valid && out_ready) begin
      k = out_total % NOUT;
      er = k / OUT;
      ec = k % OUT;
      ed = (er < SIZE && ec < SIZE) ? 32'(100 * (out_total / NOUT) + er + ec) : 32'd0;
      vectors++;
      if (out_data !== ed || out_row !== 4'(er) || out_col !== 4'(ec) ||
          out_last !== (k == NOUT - 1)) begin
        errors++;
        $display("FAIL element %0d: got %0d@(%0d,%0d) last=%b want %0d@(%0d,%0d) last=%b",
                 out_total, out_data, out_row, out_col, out_last, ed, er, ec, (k == NOUT - 1));
      end
      out_total++;
    end
    if (frame_done) fd_count++;
    held_valid = out_valid && !out_ready;
    held_data = out_data;
    held_row = out_row;
    held_col = out_col;
    @(posedge clk);
    if (hs_in) in_total++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    vectors++;
    if ({out_valid, out_data, out_row, out_col, out_last, busy, frame_done, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%0d r=%0d c=%0d l=%b busy=%b fd=%b rdy=%b want all 0",
               out_valid, out_data, out_row, out_col, out_last, busy, frame_done, in_ready);
    end
    do_reset();
    stream_cycle(1'b0, 1'b1, 1'b1);
    vectors++;
    if (s_in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: got rdy=%b busy=%b v=%b want 0 0 0", s_in_ready, busy, out_valid);
    end
    stream_cycle(1'b1, 1'b1, 1'b1);
    vectors++;
    if (s_in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL idle_start: got rdy=%b busy=%b want 0 1", s_in_ready, busy);
    end
    stream_cycle(1'b1, 1'b1, 1'b1);
    vectors++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_first_ready: got %b want 1", s_in_ready);
    end
  endtask

  task automatic test_basic_frame();
    do_reset();
    for (int cyc = 0; cyc < 600 && out_total < NOUT; cyc++) begin
      stream_cycle(loaded() < NOUT, 1'b1, 1'b1);
      if (!s_out_valid && out_total > 0 && out_total < NOUT) gaps++;
    end
    stream_cycle(1'b0, 1'b1, 1'b1);
    vectors++;
    if (out_total != NOUT || in_total != NIN || fd_count != 1 || gaps != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_totals: got out=%0d in=%0d fd=%0d gaps=%0d busy=%b want 169 49 1 0 0",
               out_total, in_total, fd_count, gaps, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] pat;
    pat = 11'b10011010011;
    do_reset();
    for (int cyc = 0; cyc < 1000 && out_total < NOUT; cyc++) begin
      stream_cycle(loaded() < NOUT, 1'b1, pat[cyc % 11]);
    end
    stream_cycle(1'b0, 1'b1, 1'b1);
    vectors++;
    if (out_total != NOUT || in_total != NIN || fd_count != 1) begin
      errors++;
      $display("FAIL backpressure_totals: got out=%0d in=%0d fd=%0d want 169 49 1",
               out_total, in_total, fd_count);
    end
  endtask

  task automatic test_input_gaps();
    int p, gap_left;
    logic v, gap_done, in_gap, in_row8;
    gap_left = 0;
    gap_done = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 600 && out_total < NOUT; cyc++) begin
      p = loaded();
      v = 1'b1;
      in_gap = 1'b0;
      in_row8 = (p >= 8 * OUT) && (p <= 8 * OUT + OUT - 1);
      if (p == 2 * OUT + 4 && !gap_done) begin
        gap_left = 3;
        gap_done = 1'b1;
      end
      if (gap_left > 0) begin
        v = 1'b0;
        gap_left--;
        in_gap = 1'b1;
      end
      if (in_row8) v = 1'b0;
      stream_cycle(p < NOUT, v, 1'b1);
      if (!s_out_valid && out_total > 0 && out_total < NOUT) gaps++;
      if (in_gap) begin
        vectors++;
        if (s_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL gap_in_ready at pos %0d: got %b want 1", p, s_in_ready);
        end
      end
      if (in_row8) begin
        vectors++;
        if (s_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL pad_in_ready at pos %0d: got %b want 0", p, s_in_ready);
        end
      end
    end
    stream_cycle(1'b0, 1'b1, 1'b1);
    vectors++;
    if (out_total != NOUT || in_total != NIN || fd_count != 1 || gaps != 3) begin
      errors++;
      $display("FAIL gaps_totals: got out=%0d in=%0d fd=%0d gaps=%0d want 169 49 1 3",
               out_total, in_total, fd_count, gaps);
    end
  endtask

  task automatic test_en_pause();
    int p, pause_left;
    logic paused;
    pause_left = 0;
    paused = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 600 && out_total < NOUT; cyc++) begin
      p = loaded();
      if (p == 10 * OUT + 3 && !paused) begin
        paused = 1'b1;
        pause_left = 5;
      end
      if (pause_left > 0) begin
        pause_left--;
        stream_cycle(1'b0, 1'b1, 1'b1);
        vectors++;
        if (s_in_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL pause_state: got rdy=%b busy=%b want 0 1", s_in_ready, busy);
        end
        if (pause_left == 0) begin
          vectors++;
          if (out_total != 10 * OUT + 3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pause_drain: got out=%0d v=%b want 133 0", out_total, out_valid);
          end
        end
      end else begin
        stream_cycle(p < NOUT, 1'b1, 1'b1);
      end
    end
    stream_cycle(1'b0, 1'b1, 1'b1);
    vectors++;
    if (out_total != NOUT || in_total != NIN || fd_count != 1) begin
      errors++;
      $display("FAIL pause_totals: got out=%0d in=%0d fd=%0d want 169 49 1",
               out_total, in_total, fd_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int cyc = 0; cyc < 300 && loaded() < 5 * OUT + 9; cyc++) begin
      stream_cycle(1'b1, 1'b1, 1'b1);
    end
    en = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got v=%b busy=%b want 1 1", out_valid, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b busy=%b rdy=%b want 0 0 0", out_valid, busy, in_ready);
    end
    repeat (2) @(negedge clk);
    in_total = 0;
    out_total = 0;
    fd_count = 0;
    prev_last_hs = 1'b0;
    held_valid = 1'b0;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 600 && out_total < NOUT; cyc++) begin
      stream_cycle(loaded() < NOUT, 1'b1, 1'b1);
    end
    stream_cycle(1'b0, 1'b1, 1'b1);
    vectors++;
    if (out_total != NOUT || in_total != NIN || fd_count != 1) begin
      errors++;
      $display("FAIL post_reset_totals: got out=%0d in=%0d fd=%0d want 169 49 1",
               out_total, in_total, fd_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int cyc = 0; cyc < 1000 && out_total < 2 * NOUT; cyc++) begin
      stream_cycle(loaded() < 2 * NOUT, 1'b1, 1'b1);
      if (!s_out_valid && out_total > 0 && out_total < 2 * NOUT) gaps++;
    end
    stream_cycle(1'b0, 1'b1, 1'b1);
    vectors++;
    if (out_total != 2 * NOUT || in_total != 2 * NIN || fd_count != 2 || gaps > 1) begin
      errors++;
      $display("FAIL b2b_totals: got out=%0d in=%0d fd=%0d gaps=%0d want 338 98 2 <=1",
               out_total, in_total, fd_count, gaps);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_input_gaps();
    test_en_pause();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fft_zero_pad.md
Name: fft_zero_pad

Overview:
- Inverse-direction companion to the FFT trim stage: takes a SIZE x SIZE tile (image or kernel) and zero-pads it to OUT_SIZE x OUT_SIZE (OUT_SIZE = 2*SIZE-1) ahead of the FFT so that the linear convolution fits without wrap-around.
- Streaming, row-major in and out, with valid/ready on both sides.
- One registered output stage.
- Sits between the tile buffer and the 2-D FFT input.

Parameters:
- SIZE, 7, input tile edge length; must be >= 2.
- DATA_W, 32, element width in bits.
- OUT_SIZE, 2*SIZE-1, derived localparam, padded edge length; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  frame enable; starts a frame from IDLE and gates progress in RUN.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_W  tile element, row-major.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  padded element, row-major.
- out_row  out  $clog2(OUT_SIZE)  row index of out_data.
- out_col  out  $clog2(OUT_SIZE)  column index of out_data.
- out_last  out  1  out_data is element (OUT_SIZE-1, OUT_SIZE-1).
- busy  out  1  state is RUN or output register still holds data.
- frame_done  out  1  one-cycle pulse after the last element handshakes.

Behaviour:
- Reset (reset=0, async):
  - Outputs: out_valid, out_data, out_row, out_col, out_last, busy, frame_done all 0; in_ready 0.
  - State: state=IDLE, position counters (r,c)=(0,0).
  - Reset mid-frame discards the frame; no partial output is emitted after release.
- States:
  - IDLE: (r,c)=(0,0). en=1 -> RUN next cycle.
  - RUN: advances one position per load; after loading (OUT_SIZE-1, OUT_SIZE-1) -> IDLE.
- Output register free condition: slot = (!out_valid || out_ready).
- Load rule in RUN with en=1 and slot=1:
  - Inside the tile (r<SIZE && c<SIZE): in_ready=1. When in_valid=1, load in_data with (r,c) and advance. When in_valid=0, no load and no advance.
  - Padding region (r>=SIZE || c>=SIZE): in_ready=0. Load zero with (r,c) and advance regardless of in_valid.
- in_ready is combinational: state==RUN && en && inside && slot. It is 0 in IDLE and in the padding region.
- Latency: 1 cycle from an accepted input, or a zero-load cycle, to out_valid.
- Full throughput: one element per cycle when out_ready=1 and in_valid=1.
- Advance: c increments; at c==OUT_SIZE-1, c wraps to 0 and r increments. No load happens beyond (OUT_SIZE-1, OUT_SIZE-1).
- Each frame consumes exactly SIZE*SIZE inputs and emits OUT_SIZE*OUT_SIZE outputs.
- out_valid:
  - Set on load.
  - Cleared on out_valid && out_ready when no new load occurs in the same cycle.
  - Simultaneous drain and load keeps out_valid=1 with the new data.
- out_data, out_row, out_col, out_last are held stable while out_valid && !out_ready.
- en=0 in RUN: no loads and counters frozen; the output register still drains on out_ready. Resumes at the same (r,c) when en returns to 1.
- frame_done: pulses one cycle after the handshake of the element with out_last=1.
- Back-to-back frames: with en held 1, the next frame starts at (0,0). Its first load occurs no earlier than the cycle after re-entering RUN, i.e. at most 1 IDLE cycle between frames.
- Data width: zeros are DATA_W'd0. Values pass through unmodified; no sign handling.

Test Plan:
- Basic frame: SIZE=7, in_data=r+c for r,c in 0..6, in_valid=1, out_ready=1, en pulsed high -> 169 outputs; out[r][c]=r+c for r,c<7, else 0. out_last only at (12,12), frame_done once, exactly 49 input handshakes.
- Backpressure: out_ready toggled 1-0-0-1 pseudo-randomly -> out_data/out_row/out_col stable while stalled; sequence identical to the basic frame; no lost or duplicated element.
- Input gaps: in_valid=0 for 3 cycles at (2,4) and during padding row 8 -> stall only at (2,4); row 8 zeros stream at 1/cycle with in_ready=0.
- en pause: en dropped at (10,3) for 5 cycles -> no loads, in_ready=0, pending output drains; resumes at (10,3); final output count 169.
- Async reset mid-frame: reset asserted between clock edges at (5,9) -> out_valid, busy, in_ready go to 0 immediately. After release with en=1, a full fresh frame starts at (0,0).
- Back-to-back: two frames with in_data=r+c then 100+r+c, en held 1 -> 338 outputs, second frame values offset by 100, two frame_done pulses, at most 1 idle cycle between frames.
